seq_multiplier: RTL
===================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter: N, 8, operand width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port: a  input  N  multiplicand, unsigned; captured on the accepted start.
REQ-006 SHALL have port: b  input  N  multiplier, unsigned; captured on the accepted start.
REQ-007 SHALL have port: busy  output  1  high while iterating (RUN state).
REQ-008 SHALL have port: done  output  1  one-cycle pulse when product is final.
REQ-009 SHALL have port: product  output  2N  unsigned a*b; registered and held until the next accepted start.
REQ-010 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL, in IDLE with start=1 at edge k, capture a and b, clear accumulator and product, set iteration count to 0, and enter RUN.
REQ-013 SHALL, in IDLE with start=0, remain in IDLE with product unchanged.
REQ-014 SHALL perform exactly one shift-add iteration per RUN cycle, for exactly N iterations (edges k+1 .. k+N).
REQ-015 SHALL, per iteration, add the multiplicand to the upper N bits of the 2N-bit accumulator when the current multiplier LSB is 1, keeping the N-bit adder carry-out as the new MSB, then shift the {carry, accumulator} right by one bit.
REQ-016 SHALL compute the add with an N-bit ripple adder with cin=0; no bit of carry SHALL be lost (result exact over 2N bits).
REQ-017 SHALL, at edge k+N, load the final 2N-bit result into product and enter DONE.
REQ-018 SHALL assert done only in DONE (cycle after edge k+N), for exactly one cycle, then return to IDLE at edge k+N+1.
REQ-019 SHALL assert busy only in RUN; busy=0 in IDLE and DONE.
REQ-020 SHALL ignore start in RUN and DONE; captured operands SHALL NOT change mid-operation.
REQ-021 SHALL accept a start asserted in the first IDLE cycle after DONE, giving a minimum issue interval of N+2 cycles.
REQ-022 SHALL leave product unaffected by changes on a/b outside the accepting edge.
REQ-023 SHALL yield product=0 for a=0 or b=0 after the full N iterations (no early termination).

Reset
REQ-024 SHALL, with reset=1 at any edge, force state=IDLE, busy=0, done=0, product=0, accumulator=0, count=0.
REQ-025 SHALL give reset priority over start and over any in-progress iteration; an aborted operation SHALL NOT produce done.
REQ-026 SHALL accept start on the first edge after reset deasserts.

Verification
REQ-027 SHALL verify N=8: a=3, b=5, start one cycle -> busy high for 8 cycles, done pulses on cycle 9 after start edge, product=15.
REQ-028 SHALL verify N=8: a=255, b=255 -> product=0xFE01 (65025), confirming adder carry-out retention.
REQ-029 SHALL verify a=0, b=200 -> full 8-cycle RUN, done pulse, product=0.
REQ-030 SHALL verify: a=6, b=7 accepted, then start held with a=9, b=9 during RUN -> product=42, single done pulse, new operation starts only once back in IDLE.
REQ-031 SHALL verify reset asserted at RUN iteration 4 of a=100, b=100 -> next cycle busy=0, done=0, product=0, no done afterward; then a=12, b=11 -> product=132.
REQ-032 SHALL verify back-to-back: start held high continuously with a=2, b=3 -> done every 10 cycles, product=6 each time.

Source files
------------

// File: rtl/seq_multiplier.sv
// Unsigned N x N -> 2N shift-add multiplier, one iteration per cycle.
// state | meaning: IDLE wait for start | RUN N shift-add steps | DONE one-cycle done pulse
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] product_q, product_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N:0]     sum;

  function automatic logic [N:0] ripple_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] s;
    logic         c;
    c = 1'b0;
    for (int i = 0; i < N; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c, s};
  endfunction

  always_comb begin
    sum = ripple_add(acc_q[2*N-1:N], mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d   = a;
          mplier_d  = b;
          acc_d     = '0;
          count_d   = '0;
          product_d = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        // carry-out becomes the new MSB before the right shift, so nothing is lost
        acc_d    = {sum, acc_q[N-1:1]};
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          product_d = {sum, acc_q[N-1:1]};
          count_d   = '0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
